// File: rtl/branch_resolve_unit.sv
// Branch resolution unit: merges ALU branch reports into the b1 update masks,
// picks the oldest mispredict in b2 and holds it as a frontend redirect.
module branch_resolve_unit #(
    parameter int NUM_PORTS = 2,
    parameter int MAX_BR    = 16,
    parameter int ROB_W     = 7,
    parameter int FTQ_W     = 6,
    parameter int VADDR_W   = 40
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           flush,
    input  logic [ROB_W-1:0]               rob_head_idx,
    input  logic [NUM_PORTS-1:0]           br_valid,
    input  logic [NUM_PORTS-1:0]           br_mispredict,
    input  logic [NUM_PORTS-1:0]           br_taken,
    input  logic [NUM_PORTS*4-1:0]         br_tag,
    input  logic [NUM_PORTS*MAX_BR-1:0]    br_mask,
    input  logic [NUM_PORTS*ROB_W-1:0]     br_rob_idx,
    input  logic [NUM_PORTS*FTQ_W-1:0]     br_ftq_idx,
    input  logic [NUM_PORTS*2-1:0]         br_pc_sel,
    input  logic [NUM_PORTS*VADDR_W-1:0]   br_jalr_target,
    input  logic [NUM_PORTS*21-1:0]        br_target_offset,
    output logic [MAX_BR-1:0]              b1_resolve_mask,
    output logic [MAX_BR-1:0]              b1_mispredict_mask,
    output logic                           b2_valid,
    output logic [ROB_W-1:0]               b2_rob_idx,
    output logic [FTQ_W-1:0]               b2_ftq_idx,
    output logic [3:0]                     b2_tag,
    output logic                           b2_taken,
    output logic [1:0]                     b2_pc_sel,
    output logic [VADDR_W-1:0]             b2_jalr_target,
    output logic [20:0]                    b2_target_offset,
    output logic                           redirect_valid,
    input  logic                           redirect_ready,
    output logic [FTQ_W-1:0]               redirect_ftq_idx,
    output logic [1:0]                     redirect_pc_sel,
    output logic [VADDR_W-1:0]             redirect_jalr_target,
    output logic [20:0]                    redirect_target_offset,
    output logic                           redirect_taken
);
    localparam int SEL_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic {IDLE, REDIRECT} state_t;

    state_t                  state_reg, state_next;
    logic                    load_next;
    logic [ROB_W-1:0]        held_rob_reg;
    logic [NUM_PORTS-1:0]    live, live_mis;
    logic [ROB_W-1:0]        port_age [NUM_PORTS];
    logic [MAX_BR-1:0]       port_onehot [NUM_PORTS];
    logic [MAX_BR-1:0]       resolve_next, mispredict_next;
    logic [SEL_W-1:0]        sel;
    logic [ROB_W-1:0]        sel_age;
    logic                    sel_found;
    logic [ROB_W-1:0]        b2_age, held_age;

    // A report is dropped when its uop depends on a branch being broadcast as mispredicted.
    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign live[gi] = br_valid[gi] & ~flush
                & ((br_mask[gi*MAX_BR +: MAX_BR] & b1_mispredict_mask) == '0);
            assign live_mis[gi]    = live[gi] & br_mispredict[gi];
            assign port_age[gi]    = br_rob_idx[gi*ROB_W +: ROB_W] - rob_head_idx;
            assign port_onehot[gi] = {{(MAX_BR-1){1'b0}}, 1'b1} << br_tag[gi*4 +: 4];
        end
    endgenerate

    always_comb begin
        resolve_next    = '0;
        mispredict_next = '0;
        sel             = '0;
        sel_age         = '0;
        sel_found       = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (live[p]) begin
                resolve_next = resolve_next | port_onehot[p];
            end
            // Strict compare keeps the lower port on an age tie.
            if (live_mis[p]) begin
                mispredict_next = mispredict_next | port_onehot[p];
                if (!sel_found || (port_age[p] < sel_age)) begin
                    sel       = SEL_W'(p);
                    sel_age   = port_age[p];
                    sel_found = 1'b1;
                end
            end
        end
    end

    assign b2_age         = b2_rob_idx - rob_head_idx;
    assign held_age       = held_rob_reg - rob_head_idx;
    assign redirect_valid = (state_reg == REDIRECT);

    always_comb begin
        state_next = state_reg;
        load_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (b2_valid) begin
                    load_next  = 1'b1;
                    state_next = REDIRECT;
                end
            end
            REDIRECT: begin
                // A younger b2 without a fire is dropped; the held redirect already covers it.
                if (b2_valid && (redirect_ready || (b2_age < held_age))) begin
                    load_next = 1'b1;
                end else if (redirect_ready && !b2_valid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            state_reg          <= IDLE;
            b1_resolve_mask    <= '0;
            b1_mispredict_mask <= '0;
            b2_valid           <= 1'b0;
        end else begin
            state_reg          <= state_next;
            b1_resolve_mask    <= resolve_next;
            b1_mispredict_mask <= mispredict_next;
            b2_valid           <= sel_found;
        end
    end

    always_ff @(posedge clock) begin
        if (sel_found) begin
            b2_rob_idx       <= br_rob_idx[sel*ROB_W +: ROB_W];
            b2_ftq_idx       <= br_ftq_idx[sel*FTQ_W +: FTQ_W];
            b2_tag           <= br_tag[sel*4 +: 4];
            b2_taken         <= br_taken[sel];
            b2_pc_sel        <= br_pc_sel[sel*2 +: 2];
            b2_jalr_target   <= br_jalr_target[sel*VADDR_W +: VADDR_W];
            b2_target_offset <= br_target_offset[sel*21 +: 21];
        end
        if (load_next) begin
            held_rob_reg           <= b2_rob_idx;
            redirect_ftq_idx       <= b2_ftq_idx;
            redirect_pc_sel        <= b2_pc_sel;
            redirect_jalr_target   <= b2_jalr_target;
            redirect_target_offset <= b2_target_offset;
            redirect_taken         <= b2_taken;
        end
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: fixed vectors, directed
// redirect sequences, and random traffic against a cycle-level reference model.
module tb_branch_resolve_unit;
    logic         clock = 1'b0;
    logic         reset, flush, redirect_ready;
    logic [6:0]   rob_head_idx;
    logic [1:0]   br_valid, br_mispredict, br_taken;
    logic [7:0]   br_tag;
    logic [31:0]  br_mask;
    logic [13:0]  br_rob_idx;
    logic [11:0]  br_ftq_idx;
    logic [3:0]   br_pc_sel;
    logic [79:0]  br_jalr_target;
    logic [41:0]  br_target_offset;
    logic [15:0]  b1_resolve_mask, b1_mispredict_mask;
    logic         b2_valid, b2_taken, redirect_valid, redirect_taken;
    logic [6:0]   b2_rob_idx;
    logic [5:0]   b2_ftq_idx, redirect_ftq_idx;
    logic [3:0]   b2_tag;
    logic [1:0]   b2_pc_sel, redirect_pc_sel;
    logic [39:0]  b2_jalr_target, redirect_jalr_target;
    logic [20:0]  b2_target_offset, redirect_target_offset;

    branch_resolve_unit dut (
        .clock(clock), .reset(reset), .flush(flush), .rob_head_idx(rob_head_idx),
        .br_valid(br_valid), .br_mispredict(br_mispredict), .br_taken(br_taken),
        .br_tag(br_tag), .br_mask(br_mask), .br_rob_idx(br_rob_idx),
        .br_ftq_idx(br_ftq_idx), .br_pc_sel(br_pc_sel), .br_jalr_target(br_jalr_target),
        .br_target_offset(br_target_offset),
        .b1_resolve_mask(b1_resolve_mask), .b1_mispredict_mask(b1_mispredict_mask),
        .b2_valid(b2_valid), .b2_rob_idx(b2_rob_idx), .b2_ftq_idx(b2_ftq_idx),
        .b2_tag(b2_tag), .b2_taken(b2_taken), .b2_pc_sel(b2_pc_sel),
        .b2_jalr_target(b2_jalr_target), .b2_target_offset(b2_target_offset),
        .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
        .redirect_ftq_idx(redirect_ftq_idx), .redirect_pc_sel(redirect_pc_sel),
        .redirect_jalr_target(redirect_jalr_target),
        .redirect_target_offset(redirect_target_offset), .redirect_taken(redirect_taken)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [6:0]  rob;
        logic [5:0]  ftq;
        logic [3:0]  tag;
        logic        taken;
        logic [1:0]  pc_sel;
        logic [39:0] jalr;
        logic [20:0] off;
    } pl_t;

    typedef struct {
        bit v0, v1, m0, m1;
        logic [3:0] t0, t1;
        logic [6:0] r0, r1, head;
        logic [15:0] e_res, e_mis;
        bit e_b2v;
        logic [6:0] e_rob;
        logic [3:0] e_tag;
    } vec_t;

    logic        pv [2], pmis [2], ptaken [2];
    logic [3:0]  ptag [2];
    logic [15:0] pmask [2];
    logic [6:0]  prob [2];
    logic [5:0]  pftq [2];
    logic [1:0]  psel [2];
    logic [39:0] pjalr [2];
    logic [20:0] poff [2];

    logic [15:0] m_res = '0, m_mis = '0;
    bit          m_b2v = 1'b0, m_rv = 1'b0;
    pl_t         m_b2, m_red;

    int n_checks = 0;
    int n_err = 0;
    vec_t vecs [8];

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int age(logic [6:0] x);
        return (int'(x) - int'(rob_head_idx) + 128) % 128;
    endfunction

    task automatic clear_ports();
        for (int p = 0; p < 2; p++) begin
            pv[p] = 1'b0; pmis[p] = 1'b0; pmask[p] = '0;
        end
    endtask

    task automatic set_port(int p, bit mis, int tag, int rob, int ftq, logic [15:0] mask);
        pv[p] = 1'b1; pmis[p] = mis; ptag[p] = 4'(tag); prob[p] = 7'(rob);
        pftq[p] = 6'(ftq); pmask[p] = mask;
        ptaken[p] = 1'($urandom_range(0, 1));
        psel[p]   = 2'($urandom_range(0, 2));
        pjalr[p]  = 40'({$urandom, $urandom});
        poff[p]   = 21'($urandom);
    endtask

    task automatic apply();
        for (int p = 0; p < 2; p++) begin
            br_valid[p] = pv[p]; br_mispredict[p] = pmis[p]; br_taken[p] = ptaken[p];
            br_tag[p*4 +: 4] = ptag[p]; br_mask[p*16 +: 16] = pmask[p];
            br_rob_idx[p*7 +: 7] = prob[p]; br_ftq_idx[p*6 +: 6] = pftq[p];
            br_pc_sel[p*2 +: 2] = psel[p]; br_jalr_target[p*40 +: 40] = pjalr[p];
            br_target_offset[p*21 +: 21] = poff[p];
        end
    endtask

    // One clock: predict the next state from the rules, clock the DUT, compare.
    task automatic tick();
        logic [15:0] n_res, n_mis;
        bit n_b2v, n_rv;
        pl_t n_b2, n_red;
        int best, best_age, a;
        apply();
        n_res = '0; n_mis = '0; best = -1; best_age = 0;
        n_b2 = m_b2; n_red = m_red; n_rv = m_rv;
        for (int p = 0; p < 2; p++) begin
            if (pv[p] && !flush && ((pmask[p] & m_mis) == 16'h0)) begin
                n_res = n_res | (16'h1 << ptag[p]);
                if (pmis[p]) begin
                    n_mis = n_mis | (16'h1 << ptag[p]);
                    a = age(prob[p]);
                    if (best < 0 || a < best_age) begin
                        best = p; best_age = a;
                    end
                end
            end
        end
        n_b2v = (best >= 0);
        if (best >= 0) begin
            n_b2.rob = prob[best]; n_b2.ftq = pftq[best]; n_b2.tag = ptag[best];
            n_b2.taken = ptaken[best]; n_b2.pc_sel = psel[best];
            n_b2.jalr = pjalr[best]; n_b2.off = poff[best];
        end
        if (!m_rv) begin
            if (m_b2v) begin
                n_rv = 1'b1; n_red = m_b2;
            end
        end else if (m_b2v && (redirect_ready || age(m_b2.rob) < age(m_red.rob))) begin
            n_red = m_b2;
        end else if (!m_b2v && redirect_ready) begin
            n_rv = 1'b0;
        end
        if (reset || flush) begin
            n_res = '0; n_mis = '0; n_b2v = 1'b0; n_rv = 1'b0;
        end
        @(posedge clock);
        #1;
        m_res = n_res; m_mis = n_mis; m_b2v = n_b2v; m_b2 = n_b2; m_rv = n_rv; m_red = n_red;
        chk("model_b1_resolve", 128'(b1_resolve_mask), 128'(m_res));
        chk("model_b1_mispredict", 128'(b1_mispredict_mask), 128'(m_mis));
        chk("model_b2_valid", 128'(b2_valid), 128'(m_b2v));
        chk("model_redirect_valid", 128'(redirect_valid), 128'(m_rv));
        if (m_b2v)
            chk("model_b2_payload", 128'({b2_rob_idx, b2_ftq_idx, b2_tag, b2_taken,
                b2_pc_sel, b2_jalr_target, b2_target_offset}), 128'(m_b2));
        if (m_rv)
            chk("model_redirect_payload", 128'({redirect_ftq_idx, redirect_pc_sel,
                redirect_jalr_target, redirect_target_offset, redirect_taken}),
                128'({m_red.ftq, m_red.pc_sel, m_red.jalr, m_red.off, m_red.taken}));
    endtask

    task automatic flush_cycle();
        clear_ports(); flush = 1'b1; tick(); flush = 1'b0;
    endtask

    // Leaves a redirect held for the given ROB/FTQ index with ready low.
    task automatic hold(int rob, int ftq);
        flush_cycle();
        redirect_ready = 1'b0;
        set_port(0, 1'b1, 1, rob, ftq, 16'h0);
        tick();
        clear_ports();
        tick();
        chk("hold_valid", 128'(redirect_valid), 128'(1));
        chk("hold_ftq", 128'(redirect_ftq_idx), 128'(ftq));
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; redirect_ready = 1'b0; rob_head_idx = '0;
        clear_ports();
        for (int p = 0; p < 2; p++) set_port(p, 1'b0, 0, 0, 0, 16'h0);
        clear_ports();
        tick(); tick();
        reset = 1'b0;
        chk("reset_b1", 128'({b1_resolve_mask, b1_mispredict_mask}), 128'(0));
        chk("reset_valids", 128'({b2_valid, redirect_valid}), 128'(0));

        //          v0 v1 m0 m1 t0 t1  r0   r1   head res      mis      b2v rob  tag
        vecs[0] = '{0, 1, 0, 0, 0, 15, 0,   0,   0,   16'h8000, 16'h0000, 0, 0,   0};
        vecs[1] = '{1, 1, 0, 0, 0, 4,  1,   2,   0,   16'h0011, 16'h0000, 0, 0,   0};
        vecs[2] = '{1, 0, 1, 0, 3, 0,  10,  0,   0,   16'h0008, 16'h0008, 1, 10,  3};
        vecs[3] = '{1, 1, 1, 1, 1, 7,  5,   125, 120, 16'h0082, 16'h0082, 1, 125, 7};
        vecs[4] = '{1, 1, 1, 1, 2, 9,  33,  33,  33,  16'h0204, 16'h0204, 1, 33,  2};
        vecs[5] = '{1, 1, 0, 1, 6, 11, 50,  90,  100, 16'h0840, 16'h0800, 1, 90,  11};
        vecs[6] = '{1, 1, 1, 1, 0, 1,  127, 0,   127, 16'h0003, 16'h0003, 1, 127, 0};
        vecs[7] = '{0, 0, 1, 1, 4, 5,  8,   9,   0,   16'h0000, 16'h0000, 0, 0,   0};
        for (int i = 0; i < 8; i++) begin
            flush_cycle();
            rob_head_idx = vecs[i].head;
            if (vecs[i].v0) set_port(0, vecs[i].m0, int'(vecs[i].t0), int'(vecs[i].r0), i, 16'h0);
            if (vecs[i].v1) set_port(1, vecs[i].m1, int'(vecs[i].t1), int'(vecs[i].r1), i + 8, 16'h0);
            if (!vecs[i].v0) begin pmis[0] = vecs[i].m0; ptag[0] = vecs[i].t0; end
            if (!vecs[i].v1) begin pmis[1] = vecs[i].m1; ptag[1] = vecs[i].t1; end
            tick();
            chk("vec_resolve", 128'(b1_resolve_mask), 128'(vecs[i].e_res));
            chk("vec_mispredict", 128'(b1_mispredict_mask), 128'(vecs[i].e_mis));
            chk("vec_b2_valid", 128'(b2_valid), 128'(vecs[i].e_b2v));
            if (vecs[i].e_b2v)
                chk("vec_b2_rob_tag", 128'({b2_rob_idx, b2_tag}), 128'({vecs[i].e_rob, vecs[i].e_tag}));
            $display("vec %0d: res=%h mis=%h b2v=%b rob=%0d", i, b1_resolve_mask,
                     b1_mispredict_mask, b2_valid, b2_rob_idx);
        end
        rob_head_idx = '0;

        // Single mispredict through to a held redirect.
        flush_cycle();
        set_port(0, 1'b1, 3, 10, 21, 16'h0);
        tick();
        chk("single_b1", 128'({b1_resolve_mask, b1_mispredict_mask}), 128'(32'h0008_0008));
        chk("single_b2", 128'({b2_valid, b2_rob_idx}), 128'({1'b1, 7'd10}));
        chk("single_no_redirect_yet", 128'(redirect_valid), 128'(0));
        clear_ports();
        tick();
        chk("single_redirect", 128'({redirect_valid, redirect_ftq_idx}), 128'({1'b1, 6'd21}));
        tick(); tick();
        chk("single_held", 128'({redirect_valid, redirect_ftq_idx}), 128'({1'b1, 6'd21}));
        redirect_ready = 1'b1;
        tick();
        chk("single_fire_idle", 128'(redirect_valid), 128'(0));
        $display("seq single: done");

        // Kill: a uop under a just-mispredicted branch must not resolve.
        flush_cycle();
        set_port(0, 1'b1, 2, 3, 3, 16'h0);
        tick();
        set_port(0, 1'b0, 5, 4, 4, 16'h0004);
        tick();
        chk("kill_resolve", 128'(b1_resolve_mask), 128'(0));
        $display("seq kill: res=%h", b1_resolve_mask);

        // Older b2 replaces the held redirect; younger one is dropped.
        hold(40, 40);
        set_port(0, 1'b1, 2, 20, 20, 16'h0);
        tick(); clear_ports(); tick();
        chk("replace_older", 128'({redirect_valid, redirect_ftq_idx}), 128'({1'b1, 6'd20}));
        set_port(0, 1'b1, 3, 60, 60, 16'h0);
        tick(); clear_ports(); tick();
        chk("drop_younger", 128'({redirect_valid, redirect_ftq_idx}), 128'({1'b1, 6'd20}));
        redirect_ready = 1'b1;
        tick();
        chk("replace_fire_idle", 128'(redirect_valid), 128'(0));
        $display("seq replace: done");

        // Fire and a new (younger) b2 in the same cycle: no bubble.
        hold(40, 40);
        set_port(0, 1'b1, 4, 70, 7, 16'h0);
        tick();
        clear_ports(); redirect_ready = 1'b1;
        tick();
        chk("fire_reload", 128'({redirect_valid, redirect_ftq_idx}), 128'({1'b1, 6'd7}));
        tick();
        chk("fire_reload_idle", 128'(redirect_valid), 128'(0));
        $display("seq fire_reload: done");

        // Flush, then reset, during REDIRECT with a pending b2.
        for (int k = 0; k < 2; k++) begin
            hold(40, 40);
            set_port(0, 1'b1, 5, 20, 20, 16'h0);
            tick();
            clear_ports();
            if (k == 0) flush = 1'b1; else reset = 1'b1;
            tick();
            flush = 1'b0; reset = 1'b0;
            chk(k == 0 ? "flush_clear" : "reset_clear",
                128'({b1_resolve_mask, b1_mispredict_mask, b2_valid, redirect_valid}), 128'(0));
            $display("seq %s: done", k == 0 ? "flush" : "reset");
        end

        // Random traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            flush = ($urandom_range(0, 39) == 0);
            redirect_ready = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) rob_head_idx = rob_head_idx + 7'($urandom_range(1, 5));
            for (int p = 0; p < 2; p++) begin
                if ($urandom_range(0, 1) == 1)
                    set_port(p, ($urandom_range(0, 2) == 0), int'($urandom_range(0, 15)),
                             int'($urandom_range(0, 127)), int'($urandom_range(0, 63)),
                             ($urandom_range(0, 3) == 0) ? (16'h1 << $urandom_range(0, 15)) : 16'h0);
                else
                    pv[p] = 1'b0;
            end
            tick();
        end
        $display("random: 3000 cycles");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
